cnt_arb_seq: RTL and testbench

CNT_ARB_SEQ -- requirements
Module: cnt_arb_seq

---
 rtl/cnt_arb_seq.sv | 115 +++++++++++
 tb/tb_cnt_arb_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cnt_arb_seq.sv
// Two-requester round-robin arbiter driving a shared up/down run counter.
// Each granted run goes IDLE -> RUN (len+1 counts) -> DONE (one-cycle pulse) -> IDLE.
module cnt_arb_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         re,
  input  logic [1:0]   req,
  input  logic [W-1:0] len0,
  input  logic [W-1:0] len1,
  input  logic [1:0]   up,
  output logic [1:0]   gnt,
  output logic [W-1:0] c,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] C_ZERO = '0;

  logic [1:0]   state_q, state_d;
  logic         ptr_q, ptr_d;
  logic [W-1:0] len_q, len_d;
  logic         up_q, up_d;
  logic [1:0]   gnt_q, gnt_d;
  logic [W-1:0] c_q, c_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         win;
  logic [W-1:0] win_len;
  logic [W-1:0] end_val;

  // Contention goes to the favoured requester; a lone request wins outright.
  always_comb begin
    win     = (req == 2'b11) ? ptr_q : req[1];
    win_len = win ? len1 : len0;
    end_val = up_q ? len_q : C_ZERO;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    up_d    = up_q;
    gnt_d   = gnt_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d = S_RUN;
          gnt_d   = win ? 2'b10 : 2'b01;
          len_d   = win_len;
          up_d    = up[win];
          c_d     = up[win] ? C_ZERO : win_len;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (c_q == end_val) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          c_d = up_q ? (c_q + C_ONE) : (c_q - C_ONE);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        // Favour whichever requester was not just served.
        ptr_d   = gnt_q[0];
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      len_q   <= '0;
      up_q    <= 1'b0;
      gnt_q   <= 2'b00;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      up_q    <= up_d;
      gnt_q   <= gnt_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt  = gnt_q;
  assign c    = c_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cnt_arb_seq.sv
// Scoreboard bench for cnt_arb_seq: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them while the block is busy.
module tb_cnt_arb_seq;

  logic       clk = 1'b0;
  logic       re;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] up;
  logic [1:0] gnt;
  logic [3:0] c;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       busy;
    logic [1:0] gnt;
    logic [3:0] c;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  cnt_arb_seq #(.W(4)) dut (
    .clk (clk),
    .re  (re),
    .req (req),
    .len0(len0),
    .len1(len1),
    .up  (up),
    .gnt (gnt),
    .c   (c),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: one comparison per cycle while busy or while expectations are pending.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (re === 1'b1 && (busy !== 1'b0 || exp_q.size() > 0)) begin
      a = '{busy: busy, gnt: gnt, c: c, done: done};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_busy: got busy=%b gnt=%b c=%0d done=%b, required idle", busy, gnt, c, done);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL cycle: got busy=%b gnt=%b c=%0d done=%b, required busy=%b gnt=%b c=%0d done=%b",
                   a.busy, a.gnt, a.c, a.done, e.busy, e.gnt, e.c, e.done);
        end else begin
          $display("ok cycle: busy=%b gnt=%b c=%0d done=%b", a.busy, a.gnt, a.c, a.done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    end else begin
      $display("ok %s: %0h", name, act);
    end
  endtask

  // Queue the RUN cycles, the DONE cycle and (optionally) the IDLE cycle after it.
  task automatic push_run(input logic [1:0] g, input int len, input logic u, input bit with_idle);
    logic [3:0] cv;
    logic [3:0] ev;
    for (int i = 0; i <= len; i++) begin
      cv = u ? 4'(i) : 4'(len - i);
      exp_q.push_back('{busy: 1'b1, gnt: g, c: cv, done: 1'b0});
    end
    ev = u ? 4'(len) : 4'd0;
    exp_q.push_back('{busy: 1'b1, gnt: g, c: ev, done: 1'b1});
    if (with_idle) exp_q.push_back('{busy: 1'b0, gnt: 2'b00, c: ev, done: 1'b0});
  endtask

  // Present a request; returns 1 time unit after the edge that should grant it.
  task automatic issue(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1, input logic [1:0] u);
    @(posedge clk); #1;
    req = r; len0 = l0; len1 = l1; up = u;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending entries, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    re = 1'b0; req = 2'b11; len0 = 4'd3; len1 = 4'd3; up = 2'b11;

    // Reset with clock running
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_out", {23'd0, gnt, c, busy, done}, 32'd0);
    end
    @(posedge clk); #1;
    req = 2'b00;
    @(posedge clk); #1;
    re = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_reset_idle", {23'd0, gnt, c, busy, done}, 32'd0);

    // Up run; input changes during the run must be ignored
    issue(2'b01, 4'd3, 4'd0, 2'b11);
    push_run(2'b01, 3, 1'b1, 1'b1);
    req = 2'b00; len0 = 4'd9; up = 2'b00;
    wait_drain("up_run", 30);
    @(negedge clk);
    chk("idle_hold_c", {28'd0, c}, 32'd3);

    // Down run on requester 1
    issue(2'b10, 4'd0, 4'd5, 2'b00);
    push_run(2'b10, 5, 1'b0, 1'b1);
    req = 2'b00;
    wait_drain("down_run", 30);

    // Fairness: both requesting, grants alternate with an IDLE cycle between runs
    issue(2'b11, 4'd1, 4'd1, 2'b11);
    push_run(2'b01, 1, 1'b1, 1'b1);
    push_run(2'b10, 1, 1'b1, 1'b1);
    push_run(2'b01, 1, 1'b1, 1'b1);
    push_run(2'b10, 1, 1'b1, 1'b1);
    begin
      int n = 0;
      while (exp_q.size() > 4 && n < 60) begin
        @(posedge clk);
        n++;
      end
      #1 req = 2'b00;
    end
    wait_drain("fairness", 60);

    // Boundaries: zero-length run and full-range up run
    issue(2'b01, 4'd0, 4'd0, 2'b01);
    push_run(2'b01, 0, 1'b1, 1'b1);
    req = 2'b00;
    wait_drain("len_zero", 20);

    issue(2'b01, 4'd15, 4'd0, 2'b01);
    push_run(2'b01, 15, 1'b1, 1'b1);
    req = 2'b00;
    wait_drain("len_max", 40);

    // Abort mid-run
    issue(2'b01, 4'd7, 4'd0, 2'b01);
    push_run(2'b01, 7, 1'b1, 1'b1);
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1 chk("abort_pre_c", {28'd0, c}, 32'd2);
    re = 1'b0;
    #1 chk("abort_immediate", {23'd0, gnt, c, busy, done}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_held", {23'd0, gnt, c, busy, done}, 32'd0);
    end
    @(posedge clk); #1;
    re = 1'b1; req = 2'b10; len1 = 4'd2; up = 2'b00;
    @(posedge clk); #1;
    push_run(2'b10, 2, 1'b0, 1'b1);
    req = 2'b00;
    chk("abort_regrant", {30'd0, gnt}, 32'd2);
    wait_drain("after_abort", 20);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
